// File: rtl/cpu_sequencer.sv
// Control-state sequencer for the 16-bit CPU: FETCH/EXEC1/EXEC2 phase strobes,
// instruction register, STP halt, run/single-step control and debug counters.
module cpu_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic [15:0]      instr_in,
  input  logic             E2,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [15:0]      instr,
  output logic             HALTED,
  output logic             BUSY,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  state_t state, state_next;
  logic   step_flag, step_next;
  logic   retire;
  logic   stp;
  logic   continue_run;

  assign stp          = (instr[15:9] == 7'b0111111);
  assign continue_run = RUN & ~step_flag;

  always_comb begin
    state_next = state;
    step_next  = step_flag;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (RUN || STEP) begin
          state_next = S_FETCH;
          step_next  = STEP & ~RUN;
        end
      end
      S_FETCH: state_next = S_EXEC1;
      S_EXEC1: begin
        if (stp) begin
          state_next = S_HALT;
          retire     = 1'b1;
        end else if (E2) begin
          state_next = S_EXEC2;
        end else begin
          retire = 1'b1;
          if (continue_run) begin
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
            step_next  = 1'b0;
          end
        end
      end
      S_EXEC2: begin
        retire = 1'b1;
        if (continue_run) begin
          state_next = S_FETCH;
        end else begin
          state_next = S_IDLE;
          step_next  = 1'b0;
        end
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Phase strobes are flops loaded from the next state so they stay one-hot with it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      step_flag <= 1'b0;
      FETCH     <= 1'b0;
      EXEC1     <= 1'b0;
      EXEC2     <= 1'b0;
      HALTED    <= 1'b0;
    end else begin
      state     <= state_next;
      step_flag <= step_next;
      FETCH     <= (state_next == S_FETCH);
      EXEC1     <= (state_next == S_EXEC1);
      EXEC2     <= (state_next == S_EXEC2);
      HALTED    <= (state_next == S_HALT);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr <= '0;
    end else if (state == S_FETCH) begin
      instr <= instr_in;
    end
  end

  assign BUSY = FETCH | EXEC1 | EXEC2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (BUSY && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (retire && (instr_count != '1)) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: free run, reset mid-EXEC2, single step,
// RUN drop, STP halt, and counter saturation on a 4-bit-counter instance.
module tb_cpu_sequencer;

  logic        CLK = 1'b0;
  logic        nRST, RUN, STEP, E2;
  logic [15:0] instr_in;
  logic        FETCH, EXEC1, EXEC2, HALTED, BUSY;
  logic [15:0] instr;
  logic [15:0] cycle_count, instr_count;

  logic        sat_rst_n, sat_run, sat_step, sat_e2;
  logic [15:0] sat_instr_in;
  logic        sat_fetch, sat_exec1, sat_exec2, sat_halted, sat_busy;
  logic [15:0] sat_instr;
  logic [3:0]  sat_cycle_count, sat_instr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] PH_IDLE = 5'b00000;
  localparam logic [4:0] PH_F    = 5'b10001;
  localparam logic [4:0] PH_E1   = 5'b01001;
  localparam logic [4:0] PH_E2   = 5'b00101;
  localparam logic [4:0] PH_HALT = 5'b00010;

  always #5 CLK = ~CLK;

  cpu_sequencer #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .RUN(RUN), .STEP(STEP), .instr_in(instr_in), .E2(E2),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .instr(instr), .HALTED(HALTED),
    .BUSY(BUSY), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  cpu_sequencer #(.CNT_W(4)) dut_sat (
    .CLK(CLK), .nRST(sat_rst_n), .RUN(sat_run), .STEP(sat_step), .instr_in(sat_instr_in),
    .E2(sat_e2), .FETCH(sat_fetch), .EXEC1(sat_exec1), .EXEC2(sat_exec2), .instr(sat_instr),
    .HALTED(sat_halted), .BUSY(sat_busy), .cycle_count(sat_cycle_count),
    .instr_count(sat_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ph(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, FETCH, EXEC1, EXEC2, HALTED, BUSY}, {27'd0, exp});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; RUN = 1'b0; STEP = 1'b0; E2 = 1'b0; instr_in = 16'h0000;
    sat_rst_n = 1'b0; sat_run = 1'b0; sat_step = 1'b0; sat_e2 = 1'b0; sat_instr_in = 16'h5000;

    // Reset state
    #12;
    chk_ph("reset_phase", PH_IDLE);
    chk("reset_instr", {16'd0, instr}, 32'h0);
    chk("reset_cycles", {16'd0, cycle_count}, 32'h0);
    chk("reset_retired", {16'd0, instr_count}, 32'h0);
    @(negedge CLK) nRST = 1'b1;
    tick();
    chk_ph("idle_no_run", PH_IDLE);

    // Free run: 5000 (no E2), 3848 (E2), 5000 (E2) then reset in EXEC2
    RUN = 1'b1; instr_in = 16'h5000;
    tick(); chk_ph("run_f1", PH_F); chk("run_f1_cyc", {16'd0, cycle_count}, 32'd0);
    tick(); chk_ph("run_e1a", PH_E1); chk("run_instr_a", {16'd0, instr}, 32'h5000);
    instr_in = 16'h3848;
    tick(); chk_ph("run_f2", PH_F); chk("run_ret1", {16'd0, instr_count}, 32'd1);
    tick(); chk_ph("run_e1b", PH_E1); chk("run_instr_b", {16'd0, instr}, 32'h3848);
    E2 = 1'b1;
    tick(); chk_ph("run_e2b", PH_E2); chk("run_instr_b2", {16'd0, instr}, 32'h3848);
    chk("run_ret_e2", {16'd0, instr_count}, 32'd1);
    E2 = 1'b0; instr_in = 16'h5000;
    tick(); chk_ph("run_f3", PH_F);
    chk("run_cyc5", {16'd0, cycle_count}, 32'd5);
    chk("run_ret2", {16'd0, instr_count}, 32'd2);
    tick(); chk_ph("run_e1c", PH_E1);
    E2 = 1'b1;
    tick(); chk_ph("run_e2c", PH_E2); chk("run_cyc7", {16'd0, cycle_count}, 32'd7);

    // Asynchronous reset during EXEC2
    nRST = 1'b0; RUN = 1'b0; E2 = 1'b0;
    #1;
    chk_ph("rst_mid_phase", PH_IDLE);
    chk("rst_mid_instr", {16'd0, instr}, 32'h0);
    chk("rst_mid_cyc", {16'd0, cycle_count}, 32'h0);
    chk("rst_mid_ret", {16'd0, instr_count}, 32'h0);
    @(negedge CLK) nRST = 1'b1;
    tick(); tick();
    chk_ph("rst_release_idle", PH_IDLE);

    // Single step of an E2 instruction; STEP during EXEC1 ignored
    STEP = 1'b1; instr_in = 16'h3848;
    tick(); chk_ph("step_f", PH_F);
    STEP = 1'b0;
    tick(); chk_ph("step_e1", PH_E1);
    STEP = 1'b1; E2 = 1'b1;
    tick(); chk_ph("step_e2", PH_E2);
    STEP = 1'b0; E2 = 1'b0;
    tick(); chk_ph("step_idle", PH_IDLE);
    chk("step_ret", {16'd0, instr_count}, 32'd1);
    chk("step_cyc", {16'd0, cycle_count}, 32'd3);
    tick(); chk_ph("step_not_queued", PH_IDLE);

    // RUN falls in EXEC1 of an E2 instruction; E2 outside EXEC1 has no effect
    RUN = 1'b1; instr_in = 16'h5000; E2 = 1'b1;
    tick(); chk_ph("drop_f", PH_F);
    tick(); chk_ph("drop_e1", PH_E1);
    RUN = 1'b0;
    tick(); chk_ph("drop_e2", PH_E2);
    E2 = 1'b0;
    tick(); chk_ph("drop_idle", PH_IDLE);
    chk("drop_ret", {16'd0, instr_count}, 32'd2);
    chk("drop_cyc", {16'd0, cycle_count}, 32'd6);

    // STP halts (takes priority over E2); RUN/STEP afterwards ignored
    RUN = 1'b1; instr_in = 16'h7E00;
    tick(); chk_ph("halt_f", PH_F);
    tick(); chk_ph("halt_e1", PH_E1); chk("halt_instr", {16'd0, instr}, 32'h7E00);
    E2 = 1'b1;
    tick(); chk_ph("halt_enter", PH_HALT);
    chk("halt_ret", {16'd0, instr_count}, 32'd3);
    chk("halt_cyc", {16'd0, cycle_count}, 32'd8);
    E2 = 1'b0; RUN = 1'b0;
    tick(); RUN = 1'b1;
    tick(); STEP = 1'b1;
    tick(); STEP = 1'b0;
    chk_ph("halt_absorb", PH_HALT);
    chk("halt_cyc_hold", {16'd0, cycle_count}, 32'd8);
    chk("halt_ret_hold", {16'd0, instr_count}, 32'd3);

    // Saturation with 4-bit counters
    @(negedge CLK) sat_rst_n = 1'b1;
    sat_run = 1'b1;
    repeat (15) tick();
    chk("sat_cyc_14", {28'd0, sat_cycle_count}, 32'hE);
    tick();
    chk("sat_cyc_15", {28'd0, sat_cycle_count}, 32'hF);
    repeat (5) tick();
    chk("sat_cyc_nowrap", {28'd0, sat_cycle_count}, 32'hF);
    chk("sat_ret_10", {28'd0, sat_instr_count}, 32'hA);
    repeat (19) tick();
    chk("sat_ret_sat", {28'd0, sat_instr_count}, 32'hF);
    chk("sat_cyc_final", {28'd0, sat_cycle_count}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
